// File: rtl/seg7_pattern_decoder.sv
// ---------------------------------------------------------------------------
// seg7_pattern_decoder
//
// Receive-side counterpart of a seven-segment encoder. The segment bus is
// sampled every cycle. A pattern must repeat for STABLE_CYCLES consecutive
// samples before it is treated as settled, which filters out glitches.
//
// A settled pattern is decoded to a hex digit. A digit event is reported on a
// valid/ready output only when the digit differs from the last settled
// pattern, so a held digit is reported once. BLANK (all segments off)
// separates two reports of the same digit. Any pattern that is neither a
// digit nor BLANK is counted as invalid.
//
// Parameters
//   STABLE_CYCLES  consecutive equal samples needed to settle (1..255)
//   ERR_W          width of the saturating invalid-pattern counter
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous reset, active-high
//   seg_in       in   [6:0] segment pattern, a=bit0 .. g=bit6
//   out_ready    in   consumer accepts out_digit this cycle
//   clear_flags  in   clears overflow and err_count on the next edge
//   out_valid    out  a decoded digit event is pending
//   out_digit    out  [3:0] decoded hex digit
//   err_invalid  out  one-cycle pulse when a settled pattern is invalid
//   err_count    out  [ERR_W-1:0] saturating count of invalid patterns
//   overflow     out  sticky, a digit event was dropped while one was pending
// ---------------------------------------------------------------------------
module seg7_pattern_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             out_ready,
  input  logic             clear_flags,
  output logic             out_valid,
  output logic [3:0]       out_digit,
  output logic             err_invalid,
  output logic [ERR_W-1:0] err_count,
  output logic             overflow
);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Classification of a segment pattern; also used to remember what the
  // last settled pattern was.
  typedef enum logic [1:0] {
    KIND_BLANK   = 2'd0,
    KIND_INVALID = 2'd1,
    KIND_DIGIT   = 2'd2
  } kind_t;

  // The counter reaches this value on the last sample before the pattern
  // is accepted, i.e. STABLE_CYCLES matching samples in total.
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  // Registers
  state_t           state_q, state_d;
  logic [6:0]       s1_q, s1_d;
  logic [7:0]       cnt_q, cnt_d;
  kind_t            last_kind_q, last_kind_d;
  logic [3:0]       last_digit_q, last_digit_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_digit_q, out_digit_d;
  logic             err_invalid_q, err_invalid_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             overflow_q, overflow_d;

  // Combinational helpers
  logic       change;
  logic       accept;
  logic       emit;
  logic       stall;
  kind_t      dec_kind;
  logic [3:0] dec_digit;

  // Pattern decoder for the sampled bus. Only the sixteen digit shapes and
  // the all-off pattern are recognised; everything else is invalid.
  always_comb begin
    dec_kind  = KIND_DIGIT;
    dec_digit = 4'h0;
    unique case (s1_q)
      7'h3F:   dec_digit = 4'h0;
      7'h06:   dec_digit = 4'h1;
      7'h5B:   dec_digit = 4'h2;
      7'h4F:   dec_digit = 4'h3;
      7'h66:   dec_digit = 4'h4;
      7'h6D:   dec_digit = 4'h5;
      7'h7D:   dec_digit = 4'h6;
      7'h07:   dec_digit = 4'h7;
      7'h7F:   dec_digit = 4'h8;
      7'h6F:   dec_digit = 4'h9;
      7'h77:   dec_digit = 4'hA;
      7'h7C:   dec_digit = 4'hB;
      7'h39:   dec_digit = 4'hC;
      7'h5E:   dec_digit = 4'hD;
      7'h79:   dec_digit = 4'hE;
      7'h71:   dec_digit = 4'hF;
      7'h00:   dec_kind  = KIND_BLANK;
      default: dec_kind  = KIND_INVALID;
    endcase
  end

  // Settling FSM. Any difference between the live bus and the previous
  // sample restarts settling. Once a pattern is accepted the FSM parks in
  // LOCKED so a held pattern is accepted only once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = seg_in;
    change  = (seg_in != s1_q);
    accept  = 1'b0;

    if (change) begin
      state_d = SETTLE;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            state_d = LOCKED;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        LOCKED: begin
          state_d = LOCKED;
        end
        default: begin
          state_d = SETTLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Accept actions. A digit is emitted only if it differs from whatever was
  // last accepted, so BLANK or an invalid pattern between two identical
  // digits lets the digit be reported again.
  always_comb begin
    last_kind_d  = last_kind_q;
    last_digit_d = last_digit_q;
    emit         = 1'b0;

    if (accept) begin
      last_kind_d = dec_kind;
      if (dec_kind == KIND_DIGIT) begin
        last_digit_d = dec_digit;
        emit = !((last_kind_q == KIND_DIGIT) && (last_digit_q == dec_digit));
      end
    end
  end

  // Output handshake. A stalled consumer keeps the pending digit stable;
  // a new event arriving during the stall is lost and flagged. When the
  // pending digit is taken on the same edge as a new emit, the new digit
  // replaces it without a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_digit_d = out_digit_q;
    overflow_d  = overflow_q;
    stall       = out_valid_q && !out_ready;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (emit) begin
      if (stall) begin
        overflow_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_digit_d = dec_digit;
      end
    end

    if (clear_flags) begin
      overflow_d = 1'b0;
    end
  end

  // Invalid-pattern reporting. The pulse always fires on an invalid accept,
  // but a simultaneous clear takes priority over the counter increment.
  always_comb begin
    err_invalid_d = accept && (dec_kind == KIND_INVALID);
    err_count_d   = err_count_q;

    if (clear_flags) begin
      err_count_d = '0;
    end else if (err_invalid_d && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  // State register with synchronous reset; reset discards any pending
  // event and restarts settling from an all-zero sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SETTLE;
      s1_q          <= 7'h00;
      cnt_q         <= 8'd0;
      last_kind_q   <= KIND_BLANK;
      last_digit_q  <= 4'h0;
      out_valid_q   <= 1'b0;
      out_digit_q   <= 4'h0;
      err_invalid_q <= 1'b0;
      err_count_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      cnt_q         <= cnt_d;
      last_kind_q   <= last_kind_d;
      last_digit_q  <= last_digit_d;
      out_valid_q   <= out_valid_d;
      out_digit_q   <= out_digit_d;
      err_invalid_q <= err_invalid_d;
      err_count_q   <= err_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_digit   = out_digit_q;
  assign err_invalid = err_invalid_q;
  assign err_count   = err_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_pattern_decoder
//
// Directed bench for seg7_pattern_decoder. Expected digit events are pushed
// into a queue as the stimulus is issued; a monitor pops and compares every
// time the DUT completes a transfer. Flag and counter values are compared
// directly at chosen points in the sequence.
// ---------------------------------------------------------------------------
module tb_seg7_pattern_decoder;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       clear_flags;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       err_invalid;
  logic [7:0] err_count;
  logic       overflow;

  int checks;
  int failures;
  logic [3:0] exp_q[$];

  seg7_pattern_decoder #(
    .STABLE_CYCLES(4),
    .ERR_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .out_ready(out_ready),
    .clear_flags(clear_flags),
    .out_valid(out_valid),
    .out_digit(out_digit),
    .err_invalid(err_invalid),
    .err_count(err_count),
    .overflow(overflow)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive a pattern and hold it for n rising edges; returns 1 time unit
  // after the last edge so outputs can be sampled safely.
  task automatic applyStimulus(input logic [6:0] pattern, input int n);
    seg_in = pattern;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens on the edge following a cycle where
  // out_valid and out_ready are both high; sample on the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_event: got digit 0x%0h expected no event at %0t",
                 out_digit, $time);
      end else begin
        checkOutput("event_digit", {28'd0, out_digit}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    seg_in      = 7'h00;
    out_ready   = 1'b1;
    clear_flags = 1'b0;

    applyStimulus(7'h00, 3);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_digit", {28'd0, out_digit}, 32'd0);
    checkOutput("reset_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    applyStimulus(7'h00, 8);

    // 1: latency of a single digit with the consumer always ready
    $display("[TB] case 1: latency");
    exp_q.push_back(4'h2);
    applyStimulus(7'h5B, 4);
    checkOutput("t1_valid_edge4", {31'd0, out_valid}, 32'd0);
    applyStimulus(7'h5B, 1);
    checkOutput("t1_valid_edge5", {31'd0, out_valid}, 32'd1);
    checkOutput("t1_digit_edge5", {28'd0, out_digit}, 32'd2);
    applyStimulus(7'h5B, 1);
    checkOutput("t1_valid_edge6", {31'd0, out_valid}, 32'd0);
    applyStimulus(7'h5B, 4);

    // 2: a glitch shorter than the settle time never produces a digit
    $display("[TB] case 2: glitch filter");
    exp_q.push_back(4'h3);
    applyStimulus(7'h06, 3);
    applyStimulus(7'h4F, 10);

    // 3: a held digit reports once; blank between repeats re-arms it
    $display("[TB] case 3: repeat via blank");
    exp_q.push_back(4'h5);
    applyStimulus(7'h6D, 20);
    applyStimulus(7'h00, 5);
    exp_q.push_back(4'h5);
    applyStimulus(7'h6D, 10);
    checkOutput("t3_queue_drained", exp_q.size(), 32'd0);

    // 4: invalid patterns, saturation and clearing
    $display("[TB] case 4: invalid patterns");
    applyStimulus(7'h01, 4);
    checkOutput("t4_pulse_before", {31'd0, err_invalid}, 32'd0);
    applyStimulus(7'h01, 1);
    checkOutput("t4_pulse", {31'd0, err_invalid}, 32'd1);
    checkOutput("t4_count_1", {24'd0, err_count}, 32'd1);
    applyStimulus(7'h01, 1);
    checkOutput("t4_pulse_end", {31'd0, err_invalid}, 32'd0);
    for (int i = 0; i < 299; i++) begin
      applyStimulus((i % 2 == 0) ? 7'h02 : 7'h01, 5);
      if (i == 98) checkOutput("t4_count_100", {24'd0, err_count}, 32'd100);
    end
    checkOutput("t4_count_sat", {24'd0, err_count}, 32'd255);
    clear_flags = 1'b1;
    applyStimulus(7'h02, 1);
    clear_flags = 1'b0;
    checkOutput("t4_count_clear", {24'd0, err_count}, 32'd0);
    applyStimulus(7'h01, 4);
    clear_flags = 1'b1;
    applyStimulus(7'h01, 1);
    clear_flags = 1'b0;
    checkOutput("t4_clear_pulse", {31'd0, err_invalid}, 32'd1);
    checkOutput("t4_clear_beats_inc", {24'd0, err_count}, 32'd0);

    // 5: stalled consumer, dropped event and sticky overflow
    $display("[TB] case 5: overflow");
    out_ready = 1'b0;
    exp_q.push_back(4'h7);
    applyStimulus(7'h07, 5);
    checkOutput("t5_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t5_overflow_0", {31'd0, overflow}, 32'd0);
    applyStimulus(7'h7F, 5);
    checkOutput("t5_digit_held", {28'd0, out_digit}, 32'd7);
    checkOutput("t5_overflow_1", {31'd0, overflow}, 32'd1);
    out_ready = 1'b1;
    applyStimulus(7'h7F, 1);
    checkOutput("t5_valid_after", {31'd0, out_valid}, 32'd0);
    checkOutput("t5_overflow_sticky", {31'd0, overflow}, 32'd1);

    // 6: reset mid-settle with an event pending
    $display("[TB] case 6: reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(7'h66, 5);
    checkOutput("t6_pending", {31'd0, out_valid}, 32'd1);
    applyStimulus(7'h6D, 3);
    rst = 1'b1;
    applyStimulus(7'h6D, 1);
    rst = 1'b0;
    checkOutput("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t6_rst_digit", {28'd0, out_digit}, 32'd0);
    checkOutput("t6_rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("t6_rst_err", {24'd0, err_count}, 32'd0);
    out_ready = 1'b1;
    exp_q.push_back(4'h5);
    applyStimulus(7'h6D, 4);
    checkOutput("t6_valid_edge4", {31'd0, out_valid}, 32'd0);
    applyStimulus(7'h6D, 1);
    checkOutput("t6_valid_edge5", {31'd0, out_valid}, 32'd1);
    checkOutput("t6_digit_edge5", {28'd0, out_digit}, 32'd5);
    applyStimulus(7'h6D, 1);
    checkOutput("t6_valid_edge6", {31'd0, out_valid}, 32'd0);

    applyStimulus(7'h6D, 5);
    checkOutput("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
